alu_scheduler: RTL
==================

// Module: alu_scheduler
// PURPOSE
//   Shares NUM_ALU multi-cycle ALU units between NUM_REQ reservation-station requesters.
//   Round-robin issue of one op/cycle to a free ALU; operands held stable while ALU computes
//   (ALU result is combinational on its operand inputs). Completed results are drained
//   round-robin onto the single common data bus (CDB). Sits between reservation stations and alu.
// PARAMETERS
//   NUM_REQ  4  number of requesters (>=2)
//   NUM_ALU  2  number of alu instances (>=1)
//   ROB_IX   2  ROB tag is ROB_IX+1 bits wide
// PORTS
//   One clock; reset is asynchronous and active-low.
//   clk_in         in   1               clock
//   rst_n_in       in   1               async active-low reset
//   flush_in       in   1               squash everything issued/pending (mispredict)
//   req_valid_in   in   NUM_REQ         requester i has an op ready
//   req_rval1_in   in   32*NUM_REQ      operand 1, slice i = [32i+31:32i]
//   req_rval2_in   in   32*NUM_REQ      operand 2
//   req_func_in    in   4*NUM_REQ       aluFunc code (types.svh encoding)
//   req_rob_ix_in  in   (ROB_IX+1)*NUM_REQ  ROB tag
//   req_grant_out  out  NUM_REQ         one-hot, combinational: op i accepted this cycle
//   alu_valid_out  out  NUM_ALU         1-cycle start pulse to alu k (its valid_in)
//   alu_rval1_out  out  32*NUM_ALU      held operand 1 to alu k
//   alu_rval2_out  out  32*NUM_ALU      held operand 2
//   alu_func_out   out  4*NUM_ALU       held func
//   alu_rob_ix_out out  (ROB_IX+1)*NUM_ALU  held tag
//   alu_ready_in   in   NUM_ALU         alu k ready_out
//   alu_valid_in   in   NUM_ALU         alu k valid_out (held until read)
//   alu_data_in    in   32*NUM_ALU      alu k data_out
//   alu_read_out   out  NUM_ALU         combinational read strobe to alu k (its read_in)
//   cdb_valid_out  out  1               registered 1-cycle CDB broadcast
//   cdb_data_out   out  32              result
//   cdb_rob_ix_out out  ROB_IX+1        result tag
// BEHAVIOUR
//   Reset (async, rst_n_in=0): all outputs 0, every ALU slot IDLE, squash bits 0, both
//     round-robin pointers 0, operand/tag registers 0. Reset mid-operation discards all work;
//     alu instances are reset in the same cycle by the top level.
//   Per-ALU slot FSM: IDLE -(issued)-> BUSY -(alu_valid_in)-> DONE -(read)-> IDLE.
//     Slot is issuable only if IDLE && alu_ready_in[k]. Own FSM, not alu_ready_in alone,
//     blocks double issue (ready_out drops one cycle late).
//   Issue (cycle T): if !flush_in and an issuable slot exists, grant the first requester with
//     req_valid_in set searching from issue pointer p (p, p+1, ... wrapping mod NUM_REQ);
//     target = lowest-index issuable slot. Latch operands/func/tag into slot regs at T edge;
//     alu_valid_out[k]=1 for cycle T+1 only; slot -> BUSY; p <- granted+1 (wrap).
//     At most one grant per cycle; no grant when no slot free or flush_in=1.
//   Slot operand outputs stay constant from T+1 until slot returns to IDLE.
//   Writeback (cycle W): among DONE slots with alu_valid_in=1 and not squashed, select first
//     from writeback pointer q (wrapping mod NUM_ALU); alu_read_out[sel]=1 in W;
//     cdb_valid_out=1, cdb_data_out=alu_data_in[sel], cdb_rob_ix_out=slot tag in W+1;
//     slot -> IDLE; q <- sel+1. One broadcast per cycle; other DONE slots wait.
//   Squash: flush_in=1 sets squash bit on every BUSY/DONE slot. Squashed DONE slots get
//     alu_read_out in the same cycle (all at once, no CDB use), clear squash, go IDLE.
//     flush_in in a writeback cycle W suppresses cdb_valid_out at W+1 (read still happens).
//   Slot freed at cycle W may be reissued at W+1 once alu_ready_in is seen high.
//   cdb_valid_out is 0 in every cycle with no selection. Latency: grant -> CDB >= 18 cycles
//     with the 15-stage alu stall.
// TESTING
//   Single op: req0 Add 5,7 tag 3 -> grant[0] same cycle, alu_valid_out[0] next cycle only,
//     CDB data 12 tag 3 exactly once; slot 0 reusable afterwards.
//   Fairness: all 4 reqs held high, 2 ALUs -> grants in order 0,1,2,3,0 as slots free; no
//     request starved; never two grants in one cycle.
//   No double issue: 3 back-to-back reqs, 2 ALUs -> third grant only after a CDB broadcast.
//   CDB contention: both ALUs finish same cycle -> two broadcasts on consecutive cycles,
//     order per q; each alu_read_out pulses exactly once.
//   Flush: flush_in while both BUSY -> zero CDB broadcasts for them, both read and IDLE,
//     no grant in flush cycle; new op after flush completes normally.
//   Reset mid-op: rst_n_in low during BUSY -> all outputs 0 immediately; after release,
//     Sub 3,5 returns 0xFFFFFFFE.

Source files
------------

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares NUM_ALU multi-cycle ALUs between NUM_REQ reservation
// stations. Round-robin issue (one op per cycle) into free ALU slots, operands
// held stable while the ALU computes, and round-robin drain of finished
// results onto the single common data bus.
module alu_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_ALU = 2,
  parameter int unsigned ROB_IX  = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          flush_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [32*NUM_REQ-1:0]         req_rval1_in,
  input  logic [32*NUM_REQ-1:0]         req_rval2_in,
  input  logic [4*NUM_REQ-1:0]          req_func_in,
  input  logic [(ROB_IX+1)*NUM_REQ-1:0] req_rob_ix_in,
  output logic [NUM_REQ-1:0]            req_grant_out,
  output logic [NUM_ALU-1:0]            alu_valid_out,
  output logic [32*NUM_ALU-1:0]         alu_rval1_out,
  output logic [32*NUM_ALU-1:0]         alu_rval2_out,
  output logic [4*NUM_ALU-1:0]          alu_func_out,
  output logic [(ROB_IX+1)*NUM_ALU-1:0] alu_rob_ix_out,
  input  logic [NUM_ALU-1:0]            alu_ready_in,
  input  logic [NUM_ALU-1:0]            alu_valid_in,
  input  logic [32*NUM_ALU-1:0]         alu_data_in,
  output logic [NUM_ALU-1:0]            alu_read_out,
  output logic                          cdb_valid_out,
  output logic [31:0]                   cdb_data_out,
  output logic [ROB_IX:0]               cdb_rob_ix_out
);

  localparam int unsigned TW  = ROB_IX + 1;
  localparam int unsigned RPW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned APW = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } slot_state_e;

  slot_state_e          slot_q [NUM_ALU];
  logic [NUM_ALU-1:0]   squash_q;
  logic [RPW-1:0]       p_q;
  logic [APW-1:0]       q_q;

  logic [NUM_ALU-1:0]   issuable;
  logic                 iss_any;
  logic [APW-1:0]       iss_tgt;
  logic                 gnt_found;
  logic [RPW-1:0]       gnt_idx;
  logic [RPW-1:0]       gnt_cand;
  logic                 issue;
  logic [31:0]          iss_rval1;
  logic [31:0]          iss_rval2;
  logic [3:0]           iss_func;
  logic [TW-1:0]        iss_tag;

  logic [NUM_ALU-1:0]   wb_cand;
  logic                 wb_fire;
  logic [APW-1:0]       wb_sel;
  logic [APW-1:0]       wb_scan;
  logic [31:0]          wb_data;
  logic [TW-1:0]        wb_tag;

  // Free-slot search: lowest-index slot that is idle and whose ALU is ready.
  always_comb begin
    issuable = '0;
    iss_any  = 1'b0;
    iss_tgt  = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      issuable[k] = (slot_q[k] == S_IDLE) && alu_ready_in[k];
      if (!iss_any && issuable[k]) begin
        iss_any = 1'b1;
        iss_tgt = APW'(k);
      end
    end
  end

  // Round-robin requester search from the issue pointer, plus grant and operand mux.
  always_comb begin
    gnt_found     = 1'b0;
    gnt_idx       = '0;
    gnt_cand      = '0;
    req_grant_out = '0;
    iss_rval1     = '0;
    iss_rval2     = '0;
    iss_func      = '0;
    iss_tag       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_cand = RPW'((32'(p_q) + 32'(i)) % NUM_REQ);
      if (!gnt_found && req_valid_in[gnt_cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = gnt_cand;
      end
    end
    issue = gnt_found && iss_any && !flush_in;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == RPW'(i)) begin
        req_grant_out[i] = issue;
        iss_rval1        = req_rval1_in[i*32 +: 32];
        iss_rval2        = req_rval2_in[i*32 +: 32];
        iss_func         = req_func_in[i*4 +: 4];
        iss_tag          = req_rob_ix_in[i*TW +: TW];
      end
    end
  end

  // Writeback selection from the writeback pointer, read strobes and CDB payload mux.
  always_comb begin
    wb_cand      = '0;
    wb_fire      = 1'b0;
    wb_sel       = '0;
    wb_scan      = '0;
    wb_data      = '0;
    wb_tag       = '0;
    alu_read_out = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      wb_cand[k] = (slot_q[k] == S_DONE) && alu_valid_in[k] && !squash_q[k];
    end
    for (int i = 0; i < NUM_ALU; i++) begin
      wb_scan = APW'((32'(q_q) + 32'(i)) % NUM_ALU);
      if (!wb_fire && wb_cand[wb_scan]) begin
        wb_fire = 1'b1;
        wb_sel  = wb_scan;
      end
    end
    for (int k = 0; k < NUM_ALU; k++) begin
      // Squashed results are discarded by reading them out without a broadcast.
      alu_read_out[k] = (wb_fire && (wb_sel == APW'(k))) ||
                        ((slot_q[k] == S_DONE) && squash_q[k]);
      if (wb_sel == APW'(k)) begin
        wb_data = alu_data_in[k*32 +: 32];
        wb_tag  = alu_rob_ix_out[k*TW +: TW];
      end
    end
  end

  // Slot FSMs, held operands, round-robin pointers and registered CDB.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NUM_ALU; k++) begin
        slot_q[k] <= S_IDLE;
      end
      squash_q       <= '0;
      p_q            <= '0;
      q_q            <= '0;
      alu_valid_out  <= '0;
      alu_rval1_out  <= '0;
      alu_rval2_out  <= '0;
      alu_func_out   <= '0;
      alu_rob_ix_out <= '0;
      cdb_valid_out  <= 1'b0;
      cdb_data_out   <= '0;
      cdb_rob_ix_out <= '0;
    end else begin
      if (issue) begin
        p_q <= (gnt_idx == RPW'(NUM_REQ - 1)) ? '0 : gnt_idx + RPW'(1);
      end
      if (wb_fire) begin
        q_q <= (wb_sel == APW'(NUM_ALU - 1)) ? '0 : wb_sel + APW'(1);
      end
      // A flush in the writeback cycle still reads the ALU but drops the broadcast.
      cdb_valid_out  <= wb_fire && !flush_in;
      cdb_data_out   <= wb_fire ? wb_data : '0;
      cdb_rob_ix_out <= wb_fire ? wb_tag : '0;
      for (int k = 0; k < NUM_ALU; k++) begin
        alu_valid_out[k] <= issue && (iss_tgt == APW'(k));
        unique case (slot_q[k])
          S_IDLE: begin
            if (issue && (iss_tgt == APW'(k))) begin
              slot_q[k]                    <= S_BUSY;
              squash_q[k]                  <= 1'b0;
              alu_rval1_out[k*32 +: 32]    <= iss_rval1;
              alu_rval2_out[k*32 +: 32]    <= iss_rval2;
              alu_func_out[k*4 +: 4]       <= iss_func;
              alu_rob_ix_out[k*TW +: TW]   <= iss_tag;
            end
          end
          S_BUSY: begin
            if (alu_valid_in[k]) begin
              slot_q[k] <= S_DONE;
            end
            if (flush_in) begin
              squash_q[k] <= 1'b1;
            end
          end
          S_DONE: begin
            if (alu_read_out[k]) begin
              slot_q[k]   <= S_IDLE;
              squash_q[k] <= 1'b0;
            end else if (flush_in) begin
              squash_q[k] <= 1'b1;
            end
          end
          default: begin
            slot_q[k] <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
